// File: rtl/decrypter_stream_pkg.sv
// ============================================================================
// Module   : decrypter_stream_pkg
// Purpose  : Shared definitions for the byte encrypter/decrypter pair. These
//            are the data width, the bit-permutation indices, the FSM state
//            type, and the byte transform functions. Both directions use
//            these functions, so the cipher has a single definition.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decrypter_stream_pkg;

  localparam int BYTE_W = 8;

  // Even bit positions {0,2,4,6} are inverted by the cipher.
  localparam logic [BYTE_W-1:0] c_EVEN_INV_MASK = 8'h55;

  // The odd bits rotate: plaintext bit X is carried in cipher bit Y.
  //   1 -> 5, 3 -> 1, 5 -> 3
  localparam int c_ROT_A_PLAIN  = 1;
  localparam int c_ROT_A_CIPHER = 5;
  localparam int c_ROT_B_PLAIN  = 3;
  localparam int c_ROT_B_CIPHER = 1;
  localparam int c_ROT_C_PLAIN  = 5;
  localparam int c_ROT_C_CIPHER = 3;

  // Bit 7 passes through untouched (apart from the key XOR).
  localparam int c_PASS_BIT = 7;

  typedef enum logic [0:0] {
    NO_KEY = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Forward transform, used on the transmit side.
  function automatic logic [BYTE_W-1:0] encrypt_byte(
    input logic [BYTE_W-1:0] plain,
    input logic [BYTE_W-1:0] key
  );
    logic [BYTE_W-1:0] p;
    p                 = (plain & c_EVEN_INV_MASK) ^ c_EVEN_INV_MASK;
    p[c_ROT_A_CIPHER] = plain[c_ROT_A_PLAIN];
    p[c_ROT_B_CIPHER] = plain[c_ROT_B_PLAIN];
    p[c_ROT_C_CIPHER] = plain[c_ROT_C_PLAIN];
    p[c_PASS_BIT]     = plain[c_PASS_BIT];
    return p ^ key;
  endfunction

  // Inverse transform: remove the key, then undo the permutation.
  function automatic logic [BYTE_W-1:0] decrypt_byte(
    input logic [BYTE_W-1:0] cipher,
    input logic [BYTE_W-1:0] key
  );
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] plain;
    p = cipher ^ key;
    // Invert the even bits. The odd bits are cleared here and refilled below.
    plain                = (p & c_EVEN_INV_MASK) ^ c_EVEN_INV_MASK;
    plain[c_ROT_A_PLAIN] = p[c_ROT_A_CIPHER];
    plain[c_ROT_B_PLAIN] = p[c_ROT_B_CIPHER];
    plain[c_ROT_C_PLAIN] = p[c_ROT_C_CIPHER];
    plain[c_PASS_BIT]    = p[c_PASS_BIT];
    return plain;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decrypter_stream_fifo.sv
// ============================================================================
// Module   : byte_fifo
// Purpose  : Small synchronous FIFO with a registered-only output path.
//            Each pointer carries an extra wrap bit, so full and empty are
//            never ambiguous. When the FIFO is empty, o_data shows the last
//            byte that was popped (0 after reset).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_push/i_pushData - write request and data (ignored when full)
//            o_full            - no free entry
//            i_pop             - consumer takes the head (ignored when empty)
//            o_valid/o_data    - head entry present / head data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wrPtr;
  logic [c_AW:0]    r_rdPtr;
  logic [WIDTH-1:0] r_lastData;

  logic w_empty;
  logic w_full;
  logic w_doPush;
  logic w_doPop;

  assign w_empty  = (r_wrPtr == r_rdPtr);
  // The FIFO is full when the low bits match and the wrap bits differ.
  assign w_full   = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                    (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  assign w_doPush = i_push & ~w_full;
  assign w_doPop  = i_pop & ~w_empty;

  // The storage array has no reset. The empty flag masks any stale entries.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr[c_AW-1:0]] <= i_pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_lastData <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + c_PTR_ONE;
      end
      if (w_doPop) begin
        r_rdPtr    <= r_rdPtr + c_PTR_ONE;
        r_lastData <= r_mem[r_rdPtr[c_AW-1:0]];
      end
    end
  end

  assign o_full  = w_full;
  assign o_valid = ~w_empty;
  // Once the FIFO drains, keep showing the byte the consumer last took.
  assign o_data  = w_empty ? r_lastData : r_mem[r_rdPtr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/decrypter_stream.sv
// ============================================================================
// Module   : decrypter_stream
// Purpose  : Receive-side byte decrypter. Ciphertext arrives on a valid/ready
//            handshake. It is decrypted under a loadable key, and the
//            plaintext is queued in a small FIFO for a valid/ready consumer.
//            The block also counts the bytes it accepts.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            key_in, key_load      - key value and capture strobe
//            key_valid             - a key has been loaded since reset
//            in_valid/in_data/in_ready    - ciphertext handshake
//            out_valid/out_data/out_ready - plaintext handshake (FIFO head)
//            byte_count            - bytes accepted since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decrypter_stream
  import decrypter_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] key_in,
  input  logic              key_load,
  output logic              key_valid,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_count
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_nextState;
  logic [BYTE_W-1:0] r_key;
  logic [CNT_W-1:0]  r_byteCount;

  logic              w_inReady;
  logic              w_keyValid;
  logic              w_fifoFull;
  logic              w_accept;
  logic [BYTE_W-1:0] w_plain;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NO_KEY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state. Once running, only rst leaves RUN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      NO_KEY:  if (key_load) w_nextState = RUN;
      RUN:     w_nextState = RUN;
      default: w_nextState = NO_KEY;
    endcase
  end

  // FSM outputs. in_ready depends only on the FIFO fill level and never on
  // out_ready, so a full FIFO refuses input even when a pop happens in the
  // same cycle.
  always_comb begin
    w_inReady  = 1'b0;
    w_keyValid = 1'b0;
    case (r_state)
      RUN: begin
        w_inReady  = ~w_fifoFull;
        w_keyValid = 1'b1;
      end
      default: begin
        w_inReady  = 1'b0;
        w_keyValid = 1'b0;
      end
    endcase
  end

  // Key register. A byte accepted on the same edge as key_load still sees
  // the old key, because w_plain is computed from r_key before the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key <= '0;
    end else if (key_load) begin
      r_key <= key_in;
    end
  end

  assign w_accept = in_valid & w_inReady;
  assign w_plain  = decrypt_byte(in_data, r_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byteCount <= '0;
    end else if (w_accept) begin
      r_byteCount <= r_byteCount + c_CNT_ONE;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_pushData (w_plain),
    .o_full     (w_fifoFull),
    .i_pop      (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data)
  );

  assign in_ready   = w_inReady;
  assign key_valid  = w_keyValid;
  assign byte_count = r_byteCount;

endmodule

`default_nettype wire
